// File: rtl/code_patch_pkg.sv
// Shared types and default sizes for the code-patch controller.
// Optional feature macro used by the top: CODE_PATCH_HIT_CNT_EN.
package code_patch_pkg;

    localparam int DEF_NUM_ENTRIES = 3;
    localparam int DEF_ADDR_W      = 13;
    localparam int DEF_DATA_W      = 22;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } patch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width with a floor of one bit so a single-entry table still has
    // a legal counter.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/code_patch_table.sv
// Patch-entry storage: write/clear port and one indexed read port.
// Ports: clk_i, rst_ni, we_i/idx_i/addr_i/data_i (write), clr_i
// (invalidate all), rd_idx_i -> rd_valid_o/rd_addr_o/rd_data_o.
module code_patch_table
    import code_patch_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = idx_w(NUM_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [ADDR_W-1:0]      r_addr [NUM_ENTRIES];
    logic [DATA_W-1:0]      r_data [NUM_ENTRIES];

    // Writes to an index with no backing entry match no slot and vanish.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (clr_i) begin
            r_valid <= '0;
        end else if (we_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (idx_i == IDX_W'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= addr_i;
                    r_data[i]  <= data_i;
                end
            end
        end
    end

    always_comb begin
        rd_valid_o = 1'b0;
        rd_addr_o  = '0;
        rd_data_o  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_valid_o = r_valid[i];
                rd_addr_o  = r_addr[i];
                rd_data_o  = r_data[i];
            end
        end
    end

endmodule

// File: rtl/code_patch_seq.sv
// Code-patch controller: arbitrates config writes vs fetch lookups and
// scans the patch table one entry per cycle with a single comparator.
// Ports: cfg_* (firmware write/clear, cfg_ready_o), si_* (fetch lookup,
// si_ready_o), rsp_valid_o/patch_o/nopg_o (response), busy_o.
// Macro CODE_PATCH_HIT_CNT_EN adds hit_cnt_o, a saturating hit counter.
module code_patch_seq
    import code_patch_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = idx_w(NUM_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_pat_gen_i,
    input  logic              cfg_we_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              cfg_clr_i,
    output logic              cfg_ready_o,
    input  logic              si_read_i,
    input  logic [ADDR_W-1:0] si_addr_i,
    output logic              si_ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] patch_o,
    output logic              nopg_o,
    output logic              busy_o
`ifdef CODE_PATCH_HIT_CNT_EN
    ,
    output logic [15:0]       hit_cnt_o
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_patch;
    logic              r_nopg;

    logic              w_idle;
    logic              w_clr_acc;
    logic              w_we_acc;
    logic              w_si_acc;
    logic              w_rd_valid;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_match;
    logic              w_start_scan;
    logic              w_resp_dis;
    logic              w_resp_hit;
    logic              w_resp_miss;

    // Clear beats write beats lookup; only IDLE accepts anything.
    assign w_idle    = (r_state == IDLE);
    assign w_clr_acc = w_idle && cfg_clr_i;
    assign w_we_acc  = w_idle && cfg_we_i && !cfg_clr_i;
    assign w_si_acc  = w_idle && si_read_i && !cfg_we_i && !cfg_clr_i;

    code_patch_table #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_table (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (w_we_acc),
        .idx_i      (cfg_idx_i),
        .addr_i     (cfg_addr_i),
        .data_i     (cfg_data_i),
        .clr_i      (w_clr_acc),
        .rd_idx_i   (r_idx),
        .rd_valid_o (w_rd_valid),
        .rd_addr_o  (w_rd_addr),
        .rd_data_o  (w_rd_data)
    );

    assign w_match = w_rd_valid && (w_rd_addr == r_addr);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_start_scan = 1'b0;
        w_resp_dis   = 1'b0;
        w_resp_hit   = 1'b0;
        w_resp_miss  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_si_acc) begin
                    if (cfg_pat_gen_i) begin
                        w_state_nx   = SCAN;
                        w_start_scan = 1'b1;
                    end else begin
                        w_state_nx = RESP;
                        w_resp_dis = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (w_match) begin
                    w_state_nx = RESP;
                    w_resp_hit = 1'b1;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nx  = RESP;
                    w_resp_miss = 1'b1;
                end
            end
            RESP: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Response fields are loaded on the edge into RESP and then held until
    // the next response overwrites them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_idx   <= '0;
            r_patch <= '0;
            r_nopg  <= 1'b1;
        end else begin
            if (w_start_scan) begin
                r_addr <= si_addr_i;
                r_idx  <= '0;
            end else if (r_state == SCAN && !w_match && r_idx != LAST_IDX) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_resp_hit) begin
                r_patch <= w_rd_data;
                r_nopg  <= 1'b0;
            end else if (w_resp_dis || w_resp_miss) begin
                r_patch <= '0;
                r_nopg  <= 1'b1;
            end
        end
    end

`ifdef CODE_PATCH_HIT_CNT_EN
    logic [15:0] r_hit_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit_cnt <= '0;
        end else if (w_clr_acc) begin
            r_hit_cnt <= '0;
        end else if (w_resp_hit && r_hit_cnt != 16'hFFFF) begin
            r_hit_cnt <= r_hit_cnt + 16'd1;
        end
    end

    assign hit_cnt_o = r_hit_cnt;
`endif

    assign cfg_ready_o = w_clr_acc || w_we_acc;
    assign si_ready_o  = w_si_acc;
    assign rsp_valid_o = (r_state == RESP);
    assign patch_o     = r_patch;
    assign nopg_o      = r_nopg;
    assign busy_o      = !w_idle;

endmodule

// File: doc/code_patch_seq.md
Name: code_patch_seq

Overview:
Controller for the code-patch table. It owns the patch-entry storage and arbitrates between firmware configuration writes and instruction-fetch lookups (si_read). A single shared comparator scans the table one entry per cycle. It returns the patch word on an address hit, or asserts nopg_o (no patch) on a miss or when patching is disabled. It sits between the fetch unit and the code-patch datapath.

Parameters:
NUM_ENTRIES, 3, number of patch table entries (≥1)
ADDR_W, 13, fetch/match address width
DATA_W, 22, patch word width
IDX_W, $clog2(NUM_ENTRIES) (min 1), entry index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_pat_gen_i  in  1  global patch enable
cfg_we_i  in  1  config write request
cfg_idx_i  in  IDX_W  entry to write
cfg_addr_i  in  ADDR_W  match address
cfg_data_i  in  DATA_W  patch word
cfg_clr_i  in  1  invalidate all entries
cfg_ready_o  out  1  config write/clear accepted this cycle
si_read_i  in  1  fetch lookup request
si_addr_i  in  ADDR_W  fetch address
si_ready_o  out  1  lookup accepted this cycle
rsp_valid_o  out  1  one-cycle response strobe
patch_o  out  DATA_W  patch word, valid with rsp_valid_o
nopg_o  out  1  no patch (miss/disabled), valid with rsp_valid_o
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: all entries invalid, addr/data zero; FSM=IDLE; rsp_valid_o=0, patch_o=0, nopg_o=1, busy_o=0. Reset mid-scan aborts the scan; no response is issued.
- FSM states: IDLE, SCAN, RESP.
- IDLE arbitration:
  - cfg_clr_i has highest priority, then cfg_we_i, then si_read_i.
  - cfg_ready_o = IDLE && (cfg_we_i || cfg_clr_i). si_ready_o = IDLE && si_read_i && !cfg_we_i && !cfg_clr_i.
  - Accepted write: entry[cfg_idx_i] = {valid=1, addr, data} at the next edge.
  - Write with cfg_idx_i ≥ NUM_ENTRIES: accepted and dropped.
  - Clear: all valid bits = 0.
  - Fetch and config in the same cycle: config wins and the fetch stalls (si_ready_o=0). The requester holds si_read_i/si_addr_i.
- Lookup accepted while cfg_pat_gen_i=0: go directly to RESP with nopg_o=1. Latency is 1 cycle.
- Lookup accepted while enabled:
  - Latch si_addr_i and set the index counter to 0. Go to SCAN.
  - SCAN compares entry[idx] with the latched address, one entry per cycle.
  - On the first valid match: latch the data and go to RESP (lowest index wins).
  - At idx = NUM_ENTRIES-1 with no match: go to RESP with a miss.
  - Worst-case latency, acceptance to rsp_valid_o: NUM_ENTRIES+1 cycles. Hit on entry k: k+2 cycles.
- RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
  - Hit: patch_o = data, nopg_o = 0.
  - Miss: patch_o = 0, nopg_o = 1.
  - patch_o/nopg_o hold their values until the next response.
- cfg_ready_o=0 and si_ready_o=0 in SCAN and RESP. The table is stable during a scan.
- cfg_pat_gen_i is sampled only at lookup acceptance. Deasserting it mid-scan does not change the result.
- The index counter saturates and does not wrap. No back-to-back lookups; IDLE occupies at least one cycle between them.

Optional Feature:
CODE_PATCH_HIT_CNT_EN:
- Defined: adds output hit_cnt_o [15:0], a saturating count of hit responses (stops at 16'hFFFF). It is reset to 0 by rst_ni and by an accepted cfg_clr_i.
- Undefined: the port and counter are absent. No other behaviour changes.

Decomposition:
- Package code_patch_pkg:
  - patch_entry_t struct {valid, addr[ADDR_W], data[DATA_W]}
  - state enum {IDLE, SCAN, RESP}
  - default width constants (ADDR_W=13, DATA_W=22, NUM_ENTRIES=3)
- Sub-module code_patch_table: entry storage, write/clear logic, indexed read port. The FSM, arbitration and comparator stay in code_patch_seq.

Test Plan:
- Reset, then lookup 13'h0A5 with enable=1 on an empty table → rsp_valid_o at cycle +4, nopg_o=1, patch_o=0.
- Write entry1 = {13'h100, 22'h3ABCD}, then lookup 13'h100 → rsp_valid_o at cycle +3, patch_o=22'h3ABCD, nopg_o=0.
- Entries 0 and 2 both match 13'h020 (data 22'h1 / 22'h2) → response at +2 with patch_o=22'h1.
- cfg_we_i and si_read_i asserted in the same IDLE cycle → cfg_ready_o=1, si_ready_o=0. Lookup is accepted next cycle and sees the new entry.
- cfg_pat_gen_i=0, lookup of a matching address → response at +1, nopg_o=1. cfg_we_i during SCAN → cfg_ready_o=0 until IDLE.
- Assert rst_ni low mid-SCAN → no rsp_valid_o, table invalid, nopg_o=1. With CODE_PATCH_HIT_CNT_EN, 3 hits then cfg_clr_i → hit_cnt_o 3 then 0.
